note_judge: RTL

// Scores player input against the falling notes. Consumes the four 11-bit note Y positions
// and per-column note-present flags from the gameplay/column stage, plus the raw arrow pads.

---
 rtl/note_judge_pkg.sv | 38 +++
 rtl/note_judge_if.sv | 31 +++
 rtl/note_judge_lane.sv | 91 +++++++++
 rtl/note_judge.sv | 121 ++++++++++++
 4 files changed

// File: rtl/note_judge_pkg.sv
// Shared types and constants for the note judging slice: judgment codes,
// screen geometry, lane indices and small arithmetic helpers.
package note_judge_pkg;

    localparam int POS_W    = 11;
    localparam int SCREEN_H = 1080;
    localparam int NOTE_H   = 50;

    // Column indices, matching the {R,D,U,L} bit order of active/btn/clear.
    localparam int COL_L = 0;
    localparam int COL_U = 1;
    localparam int COL_D = 2;
    localparam int COL_R = 3;

    typedef enum logic [1:0] {
        J_NONE    = 2'd0,
        J_PERFECT = 2'd1,
        J_GOOD    = 2'd2,
        J_MISS    = 2'd3
    } judge_t;

    // Unsigned distance between two positions.
    function automatic logic [POS_W-1:0] abs_diff(input logic [POS_W-1:0] a,
                                                  input logic [POS_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Number of set bits in a lane vector.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/note_judge_if.sv
// Bundle between the gameplay/column stage, the pads and the judge.
// master drives note positions, pads and strobes; slave is the judge.
interface note_judge_if;
    import note_judge_pkg::*;

    logic             frame;
    logic             start;
    logic [POS_W-1:0] pos_l;
    logic [POS_W-1:0] pos_u;
    logic [POS_W-1:0] pos_d;
    logic [POS_W-1:0] pos_r;
    logic [3:0]       active;
    logic [3:0]       btn;
    logic [3:0]       clear;
    logic             judge_vld;
    judge_t           judge;
    logic [15:0]      score;
    logic [9:0]       combo;
    logic [9:0]       max_combo;

    modport master (
        output frame, start, pos_l, pos_u, pos_d, pos_r, active, btn,
        input  clear, judge_vld, judge, score, combo, max_combo
    );

    modport slave (
        input  frame, start, pos_l, pos_u, pos_d, pos_r, active, btn,
        output clear, judge_vld, judge, score, combo, max_combo
    );

endinterface

// File: rtl/note_judge_lane.sv
// One column of the judge: pad synchronizer and rise detector, distance to
// the target line, armed flag and the registered clear pulse. The one-hot
// perfect/good/miss outputs are combinational and registered by the top.
module note_judge_lane
    import note_judge_pkg::*;
#(
    parameter int TARGET_Y    = 900,
    parameter int PERFECT_WIN = 16,
    parameter int GOOD_WIN    = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame,
    input  logic             active,
    input  logic             btn,
    input  logic [POS_W-1:0] pos,
    output logic             perfect,
    output logic             good,
    output logic             miss,
    output logic             clear
);

    localparam logic [POS_W-1:0] TGT_L  = POS_W'(TARGET_Y);
    localparam logic [POS_W-1:0] PWIN_L = POS_W'(PERFECT_WIN);
    localparam logic [POS_W-1:0] GWIN_L = POS_W'(GOOD_WIN);
    localparam logic [POS_W-1:0] LATE_L = POS_W'(TARGET_Y + GOOD_WIN);

    logic             sync1_r;
    logic             sync2_r;
    logic             sync3_r;
    logic             armed_r;
    logic             clear_r;
    logic             press_s;
    logic [POS_W-1:0] dist_s;
    logic             hit_s;
    logic             late_s;
    logic             perfect_s;
    logic             good_s;
    logic             miss_s;
    logic             event_s;

    // Two-flop synchronizer on the raw pad plus one delay stage for edge detect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Judge a press by distance; a late note on a frame strobe is a miss.
    // A late note is always beyond the GOOD window, so a same-cycle press
    // on it is ignored and the miss wins.
    always_comb begin
        press_s   = sync2_r & ~sync3_r;
        dist_s    = abs_diff(pos, TGT_L);
        hit_s     = active & armed_r & press_s;
        late_s    = (pos > LATE_L) ? 1'b1 : 1'b0;
        perfect_s = hit_s & (dist_s <= PWIN_L);
        good_s    = hit_s & (dist_s > PWIN_L) & (dist_s <= GWIN_L);
        miss_s    = frame & active & armed_r & late_s;
        event_s   = perfect_s | good_s | miss_s;
    end

    // Lane disarms once its note is judged and re-arms whenever the column is empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_r <= 1'b1;
            clear_r <= 1'b0;
        end else begin
            clear_r <= event_s;
            if (!active) begin
                armed_r <= 1'b1;
            end else if (event_s) begin
                armed_r <= 1'b0;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    assign perfect = perfect_s;
    assign good    = good_s;
    assign miss    = miss_s;
    assign clear   = clear_r;

endmodule

// File: rtl/note_judge.sv
// Note judge top: four lanes in parallel, per-cycle judgment counts,
// saturating score and combo, max combo tracking and the judge register.
module note_judge
    import note_judge_pkg::*;
#(
    parameter int TARGET_Y    = 900,
    parameter int PERFECT_WIN = 16,
    parameter int GOOD_WIN    = 48,
    parameter int PTS_PERFECT = 3,
    parameter int PTS_GOOD    = 1
) (
    input  logic       clk,
    input  logic       rst,
    note_judge_if.slave bus
);

    localparam logic [16:0] PTS_P_L   = 17'(PTS_PERFECT);
    localparam logic [16:0] PTS_G_L   = 17'(PTS_GOOD);
    localparam logic [10:0] COMBO_MAX = 11'd1023;

    logic [POS_W-1:0] pos_s [4];
    logic [3:0]       perfect_s;
    logic [3:0]       good_s;
    logic [3:0]       miss_s;
    logic [3:0]       clear_s;
    logic [2:0]       n_p_s;
    logic [2:0]       n_g_s;
    logic [2:0]       n_m_s;
    logic             any_s;
    logic [16:0]      score_sum_s;
    logic [15:0]      score_nxt_s;
    logic [10:0]      combo_base_s;
    logic [10:0]      combo_sum_s;
    logic [9:0]       combo_nxt_s;
    logic [9:0]       max_nxt_s;
    judge_t           judge_nxt_s;

    logic [15:0]      score_r;
    logic [9:0]       combo_r;
    logic [9:0]       max_combo_r;
    judge_t           judge_r;
    logic             judge_vld_r;

    assign pos_s[COL_L] = bus.pos_l;
    assign pos_s[COL_U] = bus.pos_u;
    assign pos_s[COL_D] = bus.pos_d;
    assign pos_s[COL_R] = bus.pos_r;

    for (genvar c = 0; c < 4; c++) begin : g_lane
        note_judge_lane #(
            .TARGET_Y    (TARGET_Y),
            .PERFECT_WIN (PERFECT_WIN),
            .GOOD_WIN    (GOOD_WIN)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .frame   (bus.frame),
            .active  (bus.active[c]),
            .btn     (bus.btn[c]),
            .pos     (pos_s[c]),
            .perfect (perfect_s[c]),
            .good    (good_s[c]),
            .miss    (miss_s[c]),
            .clear   (clear_s[c])
        );
    end

    // Aggregate lane results into next score, combo, max combo and judgment.
    always_comb begin
        n_p_s        = popcount4(perfect_s);
        n_g_s        = popcount4(good_s);
        n_m_s        = popcount4(miss_s);
        any_s        = |{perfect_s, good_s, miss_s};
        score_sum_s  = {1'b0, score_r} + (17'(n_p_s) * PTS_P_L) + (17'(n_g_s) * PTS_G_L);
        score_nxt_s  = score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
        combo_base_s = (n_m_s != 3'd0) ? 11'd0 : {1'b0, combo_r};
        combo_sum_s  = combo_base_s + 11'(n_p_s) + 11'(n_g_s);
        combo_nxt_s  = (combo_sum_s > COMBO_MAX) ? 10'd1023 : combo_sum_s[9:0];
        max_nxt_s    = (combo_nxt_s > max_combo_r) ? combo_nxt_s : max_combo_r;
        if (n_m_s != 3'd0) begin
            judge_nxt_s = J_MISS;
        end else if (n_g_s != 3'd0) begin
            judge_nxt_s = J_GOOD;
        end else begin
            judge_nxt_s = J_PERFECT;
        end
    end

    // Score/combo state; start wipes the song totals and outranks same-cycle judgments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score_r     <= 16'd0;
            combo_r     <= 10'd0;
            max_combo_r <= 10'd0;
            judge_r     <= J_NONE;
            judge_vld_r <= 1'b0;
        end else if (bus.start) begin
            score_r     <= 16'd0;
            combo_r     <= 10'd0;
            max_combo_r <= 10'd0;
            judge_r     <= J_NONE;
            judge_vld_r <= 1'b0;
        end else if (any_s) begin
            score_r     <= score_nxt_s;
            combo_r     <= combo_nxt_s;
            max_combo_r <= max_nxt_s;
            judge_r     <= judge_nxt_s;
            judge_vld_r <= 1'b1;
        end else begin
            judge_vld_r <= 1'b0;
        end
    end

    assign bus.clear     = clear_s;
    assign bus.judge_vld = judge_vld_r;
    assign bus.judge     = judge_r;
    assign bus.score     = score_r;
    assign bus.combo     = combo_r;
    assign bus.max_combo = max_combo_r;

endmodule
